laser_search_ctrl: RTL

- Search scheduler for the two-circle laser coverage problem.
- Runs after the 40 input points are loaded. Drives candidate centre pairs to a shared coverage-count engine over a req/ack handshake and keeps the best pair.
- Search is alternating coordinate descent. Each pass has two sweeps: circle 1 is swept over the full 16x16 grid with circle 2 fixed, then circle 2 is swept with circle 1 fixed.
- Asserts DONE when a whole pass brings no improvement or the pass cap is reached.

---
 rtl/laser_pkg.sv | 25 ++
 rtl/laser_search_ctrl_if.sv | 30 +++
 rtl/laser_grid_iter.sv | 43 ++++
 rtl/laser_search_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// laser_pkg: shared constants and types for the two-circle laser search.
//   COORD_W    - width of one grid coordinate (16x16 grid)
//   GRID_MAX   - largest coordinate value on the grid
//   NUM_POINTS - number of input points held in point memory
//   CNT_W      - default width of a coverage count (0..NUM_POINTS)
//   PASS_W     - width of the pass counter
//   state_t    - search scheduler FSM states
package laser_pkg;

    localparam int COORD_W    = 4;
    localparam int GRID_MAX   = 15;
    localparam int NUM_POINTS = 40;
    localparam int CNT_W      = 6;
    localparam int PASS_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEED   = 3'd1,
        S_SWEEP1 = 3'd2,
        S_SWEEP2 = 3'd3,
        S_CHECK  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/laser_search_ctrl_if.sv
// laser_search_ctrl_if: request/acknowledge link between the search scheduler
// and the shared coverage-count engine.
//   eval_req   - scheduler -> engine, candidate pair valid, held until ack
//   eval_c1x.. - scheduler -> engine, candidate centres, stable under eval_req
//   eval_ack   - engine -> scheduler, one-cycle pulse, eval_count valid
//   eval_count - engine -> scheduler, points covered by the candidate pair
// Modports: master (scheduler side), slave (engine side).
interface laser_search_ctrl_if #(
    parameter int CNT_W = 6
);

    logic                          eval_req;
    logic [laser_pkg::COORD_W-1:0] eval_c1x;
    logic [laser_pkg::COORD_W-1:0] eval_c1y;
    logic [laser_pkg::COORD_W-1:0] eval_c2x;
    logic [laser_pkg::COORD_W-1:0] eval_c2y;
    logic                          eval_ack;
    logic [CNT_W-1:0]              eval_count;

    modport master (
        output eval_req, eval_c1x, eval_c1y, eval_c2x, eval_c2y,
        input  eval_ack, eval_count
    );

    modport slave (
        input  eval_req, eval_c1x, eval_c1y, eval_c2x, eval_c2y,
        output eval_ack, eval_count
    );

endinterface

// File: rtl/laser_grid_iter.sv
// laser_grid_iter: 8-bit raster position over the 16x16 grid, x inner, y outer.
//   CLK, RST - clock, asynchronous active-high reset
//   clr      - return to (0,0) on the next edge (wins over adv)
//   adv      - step to the next raster position; 255 wraps to 0
//   x, y     - current position
//   last     - high while the position is (15,15)
module laser_grid_iter (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          clr,
    input  logic                          adv,
    output logic [laser_pkg::COORD_W-1:0] x,
    output logic [laser_pkg::COORD_W-1:0] y,
    output logic                          last
);
    import laser_pkg::*;

    logic [2*COORD_W-1:0] pos_q;
    logic [2*COORD_W-1:0] pos_d;

    always_comb begin
        pos_d = pos_q;
        if (clr) begin
            pos_d = '0;
        end else if (adv) begin
            pos_d = pos_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Low nibble is x so that a plain increment gives the x-inner raster.
    assign x    = pos_q[COORD_W-1:0];
    assign y    = pos_q[2*COORD_W-1:COORD_W];
    assign last = (x == COORD_W'(GRID_MAX)) && (y == COORD_W'(GRID_MAX));

endmodule

// File: rtl/laser_search_ctrl.sv
// laser_search_ctrl: alternating coordinate-descent search over two circle
// centres on a 16x16 grid. Each pass sweeps circle 1 with circle 2 fixed,
// then circle 2 with circle 1 fixed; the best-covering pair is kept.
//   CLK, RST          - clock, asynchronous active-high reset
//   start             - one-cycle pulse, begin a fresh search (IDLE only)
//   ev (master)       - candidate request / coverage count handshake
//   C1X, C1Y, C2X, C2Y - best centres found so far
//   best_cnt          - coverage of the best pair
//   busy              - search in progress (cycle after start until DONE)
//   DONE              - one-cycle pulse when the search ends
module laser_search_ctrl #(
    parameter int MAX_PASSES = 8,
    parameter int CNT_W      = laser_pkg::CNT_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          start,
    laser_search_ctrl_if.master           ev,
    output logic [laser_pkg::COORD_W-1:0] C1X,
    output logic [laser_pkg::COORD_W-1:0] C1Y,
    output logic [laser_pkg::COORD_W-1:0] C2X,
    output logic [laser_pkg::COORD_W-1:0] C2Y,
    output logic [CNT_W-1:0]              best_cnt,
    output logic                          busy,
    output logic                          DONE
);
    import laser_pkg::*;

    state_t               state_q, state_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic                 improved_q, improved_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [COORD_W-1:0]   fix_x_q, fix_x_d, fix_y_q, fix_y_d;
    logic [COORD_W-1:0]   b1x_q, b1x_d, b1y_q, b1y_d;
    logic [COORD_W-1:0]   b2x_q, b2x_d, b2y_q, b2y_d;
    logic [CNT_W-1:0]     bcnt_q, bcnt_d;

    logic                 grid_clr, grid_adv, grid_last;
    logic [COORD_W-1:0]   grid_x, grid_y;
    logic [COORD_W-1:0]   cand_c1x, cand_c1y, cand_c2x, cand_c2y;

    laser_grid_iter u_grid (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (grid_clr),
        .adv  (grid_adv),
        .x    (grid_x),
        .y    (grid_y),
        .last (grid_last)
    );

    // The grid always drives the moving circle; the fixed one comes from the
    // centre latched when the sweep was entered.
    always_comb begin
        if (state_q == S_SWEEP2) begin
            cand_c1x = fix_x_q;
            cand_c1y = fix_y_q;
            cand_c2x = grid_x;
            cand_c2y = grid_y;
        end else begin
            cand_c1x = grid_x;
            cand_c1y = grid_y;
            cand_c2x = fix_x_q;
            cand_c2y = fix_y_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        improved_d = improved_q;
        req_d      = req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fix_x_d    = fix_x_q;
        fix_y_d    = fix_y_q;
        b1x_d      = b1x_q;
        b1y_d      = b1y_q;
        b2x_d      = b2x_q;
        b2y_d      = b2y_q;
        bcnt_d     = bcnt_q;
        grid_clr   = 1'b0;
        grid_adv   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEED;
                    busy_d  = 1'b1;
                end
            end

            S_SEED: begin
                b1x_d      = '0;
                b1y_d      = '0;
                b2x_d      = '0;
                b2y_d      = '0;
                bcnt_d     = '0;
                pass_d     = '0;
                improved_d = 1'b0;
                fix_x_d    = '0;
                fix_y_d    = '0;
                grid_clr   = 1'b1;
                state_d    = S_SWEEP1;
            end

            S_SWEEP1, S_SWEEP2: begin
                // req is low on sweep entry and for one cycle after every
                // ack; acks seen while req is low fall through untouched.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (ev.eval_ack) begin
                    req_d = 1'b0;
                    if (ev.eval_count > bcnt_q) begin
                        b1x_d      = cand_c1x;
                        b1y_d      = cand_c1y;
                        b2x_d      = cand_c2x;
                        b2y_d      = cand_c2y;
                        bcnt_d     = ev.eval_count;
                        improved_d = 1'b1;
                    end
                    if (grid_last) begin
                        grid_clr = 1'b1;
                        if (state_q == S_SWEEP1) begin
                            // Fix circle 1 at its best, including a win on
                            // this very ack.
                            fix_x_d = b1x_d;
                            fix_y_d = b1y_d;
                            state_d = S_SWEEP2;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        grid_adv = 1'b1;
                    end
                end
            end

            S_CHECK: begin
                pass_d = pass_q + 1'b1;
                if (!improved_q || (pass_d == PASS_W'(MAX_PASSES))) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    improved_d = 1'b0;
                    fix_x_d    = b2x_q;
                    fix_y_d    = b2y_q;
                    grid_clr   = 1'b1;
                    state_d    = S_SWEEP1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            pass_q     <= '0;
            improved_q <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fix_x_q    <= '0;
            fix_y_q    <= '0;
            b1x_q      <= '0;
            b1y_q      <= '0;
            b2x_q      <= '0;
            b2y_q      <= '0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            improved_q <= improved_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fix_x_q    <= fix_x_d;
            fix_y_q    <= fix_y_d;
            b1x_q      <= b1x_d;
            b1y_q      <= b1y_d;
            b2x_q      <= b2x_d;
            b2y_q      <= b2y_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign ev.eval_req = req_q;
    assign ev.eval_c1x = cand_c1x;
    assign ev.eval_c1y = cand_c1y;
    assign ev.eval_c2x = cand_c2x;
    assign ev.eval_c2y = cand_c2y;

    assign C1X      = b1x_q;
    assign C1Y      = b1y_q;
    assign C2X      = b2x_q;
    assign C2Y      = b2y_q;
    assign best_cnt = bcnt_q;
    assign busy     = busy_q;
    assign DONE     = done_q;

endmodule
